nios2_ocimem_arbiter: RTL

Shares the single-port on-chip debug RAM (OCI RAM) between two requesters. One is the CPU-side Avalon debug memory slave. The other is the JTAG debug path, which arrives as one-cycle sysclk action strobes plus the jdo word. JTAG strobes cannot be stalled, so each is captured in a one-deep pending slot and given priority. The Avalon side is held off with waitrequest. The block sits between the debug-slave sysclk logic and the OCI RAM, and returns JTAG read data as MonDReg.

---
 rtl/nios2_ocimem_arbiter_pkg.sv | 34 +++
 rtl/nios2_ocimem_jtag_slot.sv | 134 +++++++++++++
 rtl/nios2_ocimem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/nios2_ocimem_arbiter_pkg.sv
// Shared types and jdo field layout for the OCI RAM arbiter.
// Used by the arbiter top and the JTAG pending-slot block.
package nios2_ocimem_arbiter_pkg;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RDFLAG    = 34;
    localparam int JDO_WDATA_LSB = 3;

    typedef logic [1:0] fsm_t;

    localparam fsm_t ST_IDLE  = 2'd0;
    localparam fsm_t ST_JT_RD = 2'd1;
    localparam fsm_t ST_AV_RD = 2'd2;

    typedef enum logic [1:0] {
        JOP_NONE = 2'd0,
        JOP_RD   = 2'd1,
        JOP_WR   = 2'd2
    } jop_e;

    // The slot address lives outside the struct because its width
    // follows the ADDR_W parameter of the instantiating module.
    typedef struct packed {
        jop_e        op;
        logic        inc;
        logic [31:0] data;
    } jslot_t;

    function automatic logic [31:0] jdo_wdata(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_WDATA_LSB +: 32];
    endfunction

endpackage

// File: rtl/nios2_ocimem_jtag_slot.sv
// JTAG strobe decode, one-deep pending slot, address pointer, overrun.
// The head is the slot if full, else the strobe of this cycle.
module nios2_ocimem_jtag_slot
    import nios2_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              act_a_i,
    input  logic              act_b_i,
    input  logic              noact_a_i,
    input  logic [JDO_W-1:0]  jdo_i,
    input  logic              issue_i,
    input  logic              rd_done_i,
    output jop_e              head_op_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [31:0]       head_data_o,
    output logic [ADDR_W-1:0] jtag_addr_o,
    output logic              overrun_o
);

    jslot_t            slot_q, slot_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rd_inc_q, rd_inc_d;
    logic              ovr_q, ovr_d;

    jslot_t            fresh;
    logic [ADDR_W-1:0] fresh_addr;
    logic [ADDR_W-1:0] jdo_addr;
    logic              slot_full;
    logic              owed;
    logic              head_inc;
    logic              unused_jdo;

    assign jdo_addr   = jdo_i[JDO_ADDR_LSB +: ADDR_W];
    assign slot_full  = (slot_q.op != JOP_NONE);
    assign unused_jdo = ^{jdo_i[JDO_W-1:35], jdo_i[2:0]};

    // Decode this cycle's strobe; a queued op targets the pointer value
    // it will see once every increment already owed has been applied.
    always_comb begin
        fresh      = '{op: JOP_NONE, inc: 1'b0, data: 32'h0};
        owed       = rd_inc_q | (slot_full & issue_i & slot_q.inc);
        fresh_addr = ptr_q + ADDR_W'(owed);
        unique case (1'b1)
            act_a_i: begin
                if (jdo_i[JDO_RDFLAG]) begin
                    fresh.op = JOP_RD;
                end
                fresh_addr = jdo_addr;
            end
            act_b_i: begin
                fresh.op   = JOP_WR;
                fresh.inc  = 1'b1;
                fresh.data = jdo_wdata(jdo_i);
            end
            noact_a_i: begin
                fresh.op  = JOP_RD;
                fresh.inc = 1'b1;
            end
            default: ;
        endcase
    end

    // Head of queue: a full slot is older than the incoming strobe.
    always_comb begin
        if (slot_full) begin
            head_op_o   = slot_q.op;
            head_addr_o = slot_addr_q;
            head_data_o = slot_q.data;
            head_inc    = slot_q.inc;
        end else begin
            head_op_o   = fresh.op;
            head_addr_o = fresh_addr;
            head_data_o = fresh.data;
            head_inc    = fresh.inc;
        end
    end

    // Slot fill/drain, pointer update and sticky overrun.
    always_comb begin
        slot_d      = slot_q;
        slot_addr_d = slot_addr_q;
        ptr_d       = ptr_q;
        rd_inc_d    = rd_inc_q;
        ovr_d       = ovr_q;
        if (issue_i && slot_full) begin
            slot_d.op = JOP_NONE;
        end
        // A strobe issued straight through (slot empty) is not stored.
        if (fresh.op != JOP_NONE && (slot_full || !issue_i)) begin
            slot_d      = fresh;
            slot_addr_d = fresh_addr;
        end
        if (fresh.op != JOP_NONE && slot_full && !issue_i) begin
            ovr_d = 1'b1;
        end
        if (rd_done_i) begin
            rd_inc_d = 1'b0;
        end
        if (issue_i && head_op_o == JOP_RD) begin
            rd_inc_d = head_inc;
        end
        if (act_a_i) begin
            ptr_d = jdo_addr;
        end else if ((issue_i && head_op_o == JOP_WR && head_inc) ||
                     (rd_done_i && rd_inc_q)) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    // Slot and pointer state, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q      <= '{op: JOP_NONE, inc: 1'b0, data: 32'h0};
            slot_addr_q <= '0;
            ptr_q       <= '0;
            rd_inc_q    <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            slot_addr_q <= slot_addr_d;
            ptr_q       <= ptr_d;
            rd_inc_q    <= rd_inc_d;
            ovr_q       <= ovr_d;
        end
    end

    assign jtag_addr_o = ptr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Arbitrates the single-port OCI RAM between JTAG and Avalon.
// JTAG has priority; Avalon is held off with waitrequest.
module nios2_ocimem_arbiter
    import nios2_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    input  logic              av_debugaccess,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] av_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [3:0]        ram_be,
    output logic [DATA_W-1:0] ram_wrdata,
    input  logic [DATA_W-1:0] ram_rddata,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] jtag_addr,
    output logic              jtag_overrun
);

    fsm_t              state_q, state_d;
    logic              run_q;
    logic [DATA_W-1:0] mon_q, mon_d;
    logic [DATA_W-1:0] avrd_q, avrd_d;

    jop_e              head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_data;
    logic              issue;
    logic              rd_done;

    nios2_ocimem_jtag_slot #(
        .ADDR_W (ADDR_W)
    ) u_slot (
        .clk         (clk),
        .reset_n     (reset_n),
        .act_a_i     (take_action_ocimem_a),
        .act_b_i     (take_action_ocimem_b),
        .noact_a_i   (take_no_action_ocimem_a),
        .jdo_i       (jdo),
        .issue_i     (issue),
        .rd_done_i   (rd_done),
        .head_op_o   (head_op),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .jtag_addr_o (jtag_addr),
        .overrun_o   (jtag_overrun)
    );

    // Grant, RAM drive and read-return; quiet until the first edge
    // after reset so no RAM access leaks out while reset is low.
    always_comb begin
        state_d        = state_q;
        issue          = 1'b0;
        rd_done        = 1'b0;
        mon_d          = mon_q;
        avrd_d         = avrd_q;
        av_waitrequest = 1'b1;
        av_readdata    = avrd_q;
        ram_addr       = '0;
        ram_wr         = 1'b0;
        ram_be         = 4'h0;
        ram_wrdata     = '0;
        if (run_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (head_op != JOP_NONE) begin
                        issue    = 1'b1;
                        ram_addr = head_addr;
                        if (head_op == JOP_WR) begin
                            ram_wr     = 1'b1;
                            ram_be     = 4'hF;
                            ram_wrdata = DATA_W'(head_data);
                        end else begin
                            state_d = ST_JT_RD;
                        end
                    end else if (av_write) begin
                        // Without debugaccess the handshake still
                        // completes so the master is never stuck.
                        ram_addr       = av_address;
                        ram_wr         = av_debugaccess;
                        ram_be         = av_debugaccess ? av_byteenable : 4'h0;
                        ram_wrdata     = av_writedata;
                        av_waitrequest = 1'b0;
                    end else if (av_read) begin
                        ram_addr = av_address;
                        state_d  = ST_AV_RD;
                    end
                end
                ST_JT_RD: begin
                    mon_d   = ram_rddata;
                    rd_done = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_AV_RD: begin
                    avrd_d         = ram_rddata;
                    av_readdata    = ram_rddata;
                    av_waitrequest = 1'b0;
                    state_d        = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM and read-data holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            mon_q   <= '0;
            avrd_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            mon_q   <= mon_d;
            avrd_q  <= avrd_d;
        end
    end

    assign MonDReg = mon_q;

endmodule
